// File: rtl/cache_mem_arbiter.sv
// Shares one cache-side memory port between icache/dcache refills and a one-deep dcache write-back buffer.
// ARB_RR_EN selects round-robin read arbitration; fixed priority (dcache first) otherwise.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_rd_req,
  input  logic [2:0]        ic_rd_type,
  input  logic [ADDR_W-1:0] ic_rd_addr,
  output logic              ic_rd_rdy,
  output logic              ic_ret_valid,
  output logic              ic_ret_last,
  output logic [DATA_W-1:0] ic_ret_data,
  input  logic              dc_rd_req,
  input  logic [2:0]        dc_rd_type,
  input  logic [ADDR_W-1:0] dc_rd_addr,
  output logic              dc_rd_rdy,
  output logic              dc_ret_valid,
  output logic              dc_ret_last,
  output logic [DATA_W-1:0] dc_ret_data,
  input  logic              dc_wr_req,
  input  logic [2:0]        dc_wr_type,
  input  logic [ADDR_W-1:0] dc_wr_addr,
  input  logic [3:0]        dc_wr_wstrb,
  input  logic [LINE_W-1:0] dc_wr_data,
  output logic              dc_wr_rdy,
  output logic              mem_rd_req,
  output logic [2:0]        mem_rd_type,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_rdy,
  input  logic              mem_ret_valid,
  input  logic              mem_ret_last,
  input  logic [DATA_W-1:0] mem_ret_data,
  output logic              mem_wr_req,
  output logic [2:0]        mem_wr_type,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [3:0]        mem_wr_wstrb,
  output logic [LINE_W-1:0] mem_wr_data,
  input  logic              mem_wr_rdy,
  input  logic              mem_wr_done
);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_REQ  = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_REQ  = 2'd1;
  localparam logic [1:0] W_WAIT = 2'd2;

  logic [1:0]        r_state, r_next;
  logic [1:0]        w_state, w_next;
  logic              rd_dc_q;
  logic [2:0]        rd_type_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [2:0]        wr_type_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [3:0]        wr_wstrb_q;
  logic [LINE_W-1:0] wr_data_q;
  logic              wr_acc, ic_blk, dc_blk, ic_ok, dc_ok, pick_dc, rd_open, rd_hs;
  logic              ic_sel, dc_sel;

  assign dc_wr_rdy = !reset && (w_state == W_IDLE);
  assign wr_acc    = dc_wr_rdy && dc_wr_req;

  // A read must not overtake a pending write-back to the same line.
  always_comb begin
    ic_blk = ((w_state != W_IDLE) && (ic_rd_addr[ADDR_W-1:4] == wr_addr_q[ADDR_W-1:4])) ||
             (wr_acc && (ic_rd_addr[ADDR_W-1:4] == dc_wr_addr[ADDR_W-1:4]));
    dc_blk = ((w_state != W_IDLE) && (dc_rd_addr[ADDR_W-1:4] == wr_addr_q[ADDR_W-1:4])) ||
             (wr_acc && (dc_rd_addr[ADDR_W-1:4] == dc_wr_addr[ADDR_W-1:4]));
    ic_ok  = ic_rd_req && !ic_blk;
    dc_ok  = dc_rd_req && !dc_blk;
  end

`ifdef ARB_RR_EN
  logic last_dc;

  assign pick_dc = dc_ok && !(ic_ok && last_dc);

  always_ff @(posedge clk) begin
    if (reset)      last_dc <= 1'b0;
    else if (rd_hs) last_dc <= dc_rd_rdy;
  end
`else
  assign pick_dc = dc_ok;
`endif

  assign rd_open   = !reset && (r_state == R_IDLE);
  assign dc_rd_rdy = rd_open && pick_dc;
  assign ic_rd_rdy = rd_open && ic_ok && !pick_dc;
  assign rd_hs     = ic_rd_rdy || dc_rd_rdy;

  // Read FSM next state
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (rd_hs) r_next = R_REQ;
      R_REQ:   if (mem_rd_rdy) r_next = R_DATA;
      R_DATA:  if (mem_ret_valid && mem_ret_last) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Write FSM next state
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (wr_acc) w_next = W_REQ;
      W_REQ:   if (mem_wr_rdy) w_next = W_WAIT;
      W_WAIT:  if (mem_wr_done) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
    end
  end

  // Latched read request and write-back buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_dc_q    <= 1'b0;
      rd_type_q  <= 3'd0;
      rd_addr_q  <= '0;
      wr_type_q  <= 3'd0;
      wr_addr_q  <= '0;
      wr_wstrb_q <= 4'd0;
      wr_data_q  <= '0;
    end else begin
      if (rd_hs) begin
        rd_dc_q   <= dc_rd_rdy;
        rd_type_q <= dc_rd_rdy ? dc_rd_type : ic_rd_type;
        rd_addr_q <= dc_rd_rdy ? dc_rd_addr : ic_rd_addr;
      end
      if (wr_acc) begin
        wr_type_q  <= dc_wr_type;
        wr_addr_q  <= dc_wr_addr;
        wr_wstrb_q <= dc_wr_wstrb;
        wr_data_q  <= dc_wr_data;
      end
    end
  end

  assign mem_rd_req   = (r_state == R_REQ);
  assign mem_rd_type  = rd_type_q;
  assign mem_rd_addr  = rd_addr_q;
  assign mem_wr_req   = (w_state == W_REQ);
  assign mem_wr_type  = wr_type_q;
  assign mem_wr_addr  = wr_addr_q;
  assign mem_wr_wstrb = wr_wstrb_q;
  assign mem_wr_data  = wr_data_q;

  // Return beats pass straight through to the owner only
  assign ic_sel       = (r_state == R_DATA) && !rd_dc_q;
  assign dc_sel       = (r_state == R_DATA) && rd_dc_q;
  assign ic_ret_valid = ic_sel && mem_ret_valid;
  assign ic_ret_last  = ic_sel && mem_ret_last;
  assign ic_ret_data  = ic_sel ? mem_ret_data : '0;
  assign dc_ret_valid = dc_sel && mem_ret_valid;
  assign dc_ret_last  = dc_sel && mem_ret_last;
  assign dc_ret_data  = dc_sel ? mem_ret_data : '0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: transaction-level model of reads, write-back buffer and hazards.
module tb_cache_mem_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LINE_W = 128;

  logic clk = 1'b0;
  logic reset;
  logic ic_rd_req, dc_rd_req, dc_wr_req;
  logic [2:0] ic_rd_type, dc_rd_type, dc_wr_type;
  logic [ADDR_W-1:0] ic_rd_addr, dc_rd_addr, dc_wr_addr;
  logic [3:0] dc_wr_wstrb;
  logic [LINE_W-1:0] dc_wr_data;
  logic ic_rd_rdy, dc_rd_rdy, dc_wr_rdy;
  logic ic_ret_valid, ic_ret_last, dc_ret_valid, dc_ret_last;
  logic [DATA_W-1:0] ic_ret_data, dc_ret_data;
  logic mem_rd_req, mem_rd_rdy, mem_ret_valid, mem_ret_last;
  logic [2:0] mem_rd_type, mem_wr_type;
  logic [ADDR_W-1:0] mem_rd_addr, mem_wr_addr;
  logic [DATA_W-1:0] mem_ret_data;
  logic mem_wr_req, mem_wr_rdy, mem_wr_done;
  logic [3:0] mem_wr_wstrb;
  logic [LINE_W-1:0] mem_wr_data;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .reset(reset),
    .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
    .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last), .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
    .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr),
    .dc_wr_wstrb(dc_wr_wstrb), .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
    .mem_rd_req(mem_rd_req), .mem_rd_type(mem_rd_type), .mem_rd_addr(mem_rd_addr), .mem_rd_rdy(mem_rd_rdy),
    .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last), .mem_ret_data(mem_ret_data),
    .mem_wr_req(mem_wr_req), .mem_wr_type(mem_wr_type), .mem_wr_addr(mem_wr_addr),
    .mem_wr_wstrb(mem_wr_wstrb), .mem_wr_data(mem_wr_data),
    .mem_wr_rdy(mem_wr_rdy), .mem_wr_done(mem_wr_done)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: phases 0 idle / 1 request issued / 2 data or response pending
  int rd_ph = 0, wb_ph = 0;
  bit m_owner_dc = 0, m_last_dc = 0;
  logic [2:0] m_rd_type = '0, m_wr_type = '0;
  logic [31:0] m_rd_addr = '0, m_wr_addr = '0;
  logic [3:0] m_wstrb = '0;
  logic [127:0] m_wdata = '0;
  int beat = 0, wait_cnt = 0, done_delay = 0, next_done = -1;
  bit fast = 0;
  int done_cyc = -1, dc_grant_cyc = -1, wr_acc_cyc = -1;
  int ic_beats = 0, dc_beats = 0;
  bit grants[$];
  logic obs_ic_rdy, obs_dc_rdy, obs_wr_rdy;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit same_line(input logic [31:0] a, input logic [31:0] b);
    return a[31:4] == b[31:4];
  endfunction

  // Downstream memory behaviour, including spurious strobes it must ignore
  task automatic drive_mem();
    mem_rd_rdy   = (rd_ph == 1) && (fast || ($urandom % 2 == 0));
    mem_ret_data = $urandom;
    if (rd_ph == 2) begin
      mem_ret_valid = fast || ($urandom % 4 != 0);
      mem_ret_last  = mem_ret_valid && (beat == 3);
    end else begin
      mem_ret_valid = ($urandom % 8 == 0);
      mem_ret_last  = 1'($urandom);
    end
    mem_wr_rdy  = (wb_ph == 1) && (fast || ($urandom % 2 == 0));
    mem_wr_done = (wb_ph == 2) ? (wait_cnt >= done_delay) : ($urandom % 8 == 0);
  endtask

  // One clock: drive memory side, check every output, advance the model
  task automatic tick();
    bit wacc, ic_ok, dc_ok, pick_dc, open, e_ic, e_dc, e_wr, sel_ic, sel_dc;
    bit drop_ic = 0, drop_dc = 0, drop_wr = 0;
    drive_mem();
    #1;
    wacc  = !reset && wb_ph == 0 && dc_wr_req;
    ic_ok = ic_rd_req && !((wb_ph != 0 && same_line(ic_rd_addr, m_wr_addr)) ||
                           (wacc && same_line(ic_rd_addr, dc_wr_addr)));
    dc_ok = dc_rd_req && !((wb_ph != 0 && same_line(dc_rd_addr, m_wr_addr)) ||
                           (wacc && same_line(dc_rd_addr, dc_wr_addr)));
`ifdef ARB_RR_EN
    pick_dc = dc_ok && (ic_ok ? !m_last_dc : 1'b1);
`else
    pick_dc = dc_ok;
`endif
    open = !reset && rd_ph == 0;
    e_dc = open && pick_dc;
    e_ic = open && ic_ok && !pick_dc;
    e_wr = !reset && wb_ph == 0;
    sel_ic = rd_ph == 2 && !m_owner_dc;
    sel_dc = rd_ph == 2 && m_owner_dc;
    obs_ic_rdy = ic_rd_rdy; obs_dc_rdy = dc_rd_rdy; obs_wr_rdy = dc_wr_rdy;
    chk("ic_rd_rdy", ic_rd_rdy, e_ic);
    chk("dc_rd_rdy", dc_rd_rdy, e_dc);
    chk("dc_wr_rdy", dc_wr_rdy, e_wr);
    chk("mem_rd_req", mem_rd_req, rd_ph == 1);
    chk("mem_rd_type", mem_rd_type, m_rd_type);
    chk("mem_rd_addr", mem_rd_addr, m_rd_addr);
    chk("mem_wr_req", mem_wr_req, wb_ph == 1);
    chk("mem_wr_type", mem_wr_type, m_wr_type);
    chk("mem_wr_addr", mem_wr_addr, m_wr_addr);
    chk("mem_wr_wstrb", mem_wr_wstrb, m_wstrb);
    chk("mem_wr_data", mem_wr_data, m_wdata);
    chk("ic_ret_valid", ic_ret_valid, sel_ic && mem_ret_valid);
    chk("ic_ret_last", ic_ret_last, sel_ic && mem_ret_last);
    chk("ic_ret_data", ic_ret_data, sel_ic ? mem_ret_data : 32'h0);
    chk("dc_ret_valid", dc_ret_valid, sel_dc && mem_ret_valid);
    chk("dc_ret_last", dc_ret_last, sel_dc && mem_ret_last);
    chk("dc_ret_data", dc_ret_data, sel_dc ? mem_ret_data : 32'h0);
    if (ic_ret_valid === 1'b1) ic_beats++;
    if (dc_ret_valid === 1'b1) dc_beats++;
    @(posedge clk);
    cyc++;
    if (reset) begin
      rd_ph = 0; wb_ph = 0; beat = 0; wait_cnt = 0;
      m_owner_dc = 0; m_last_dc = 0;
      m_rd_type = '0; m_rd_addr = '0; m_wr_type = '0; m_wr_addr = '0; m_wstrb = '0; m_wdata = '0;
    end else begin
      if (rd_ph == 0 && (e_ic || e_dc)) begin
        rd_ph = 1;
        m_owner_dc = e_dc;
        m_last_dc = e_dc;
        m_rd_type = e_dc ? dc_rd_type : ic_rd_type;
        m_rd_addr = e_dc ? dc_rd_addr : ic_rd_addr;
        grants.push_back(e_dc);
        if (e_dc) begin dc_grant_cyc = cyc; drop_dc = 1; end
        else drop_ic = 1;
      end else if (rd_ph == 1 && mem_rd_rdy) begin
        rd_ph = 2; beat = 0;
      end else if (rd_ph == 2 && mem_ret_valid) begin
        beat++;
        if (mem_ret_last) rd_ph = 0;
      end
      if (wb_ph == 0 && dc_wr_req) begin
        wb_ph = 1;
        m_wr_type = dc_wr_type; m_wr_addr = dc_wr_addr; m_wstrb = dc_wr_wstrb; m_wdata = dc_wr_data;
        wr_acc_cyc = cyc; drop_wr = 1;
        done_delay = (next_done < 0) ? int'($urandom % 5) : next_done;
      end else if (wb_ph == 1 && mem_wr_rdy) begin
        wb_ph = 2; wait_cnt = 0;
      end else if (wb_ph == 2) begin
        if (mem_wr_done) begin wb_ph = 0; done_cyc = cyc; end
        else wait_cnt++;
      end
    end
    #1;
    if (drop_ic) ic_rd_req = 0;
    if (drop_dc) dc_rd_req = 0;
    if (drop_wr) dc_wr_req = 0;
  endtask

  task automatic drain(input string tag);
    bit idle = 0;
    for (int i = 0; i < 400; i++) begin
      idle = !ic_rd_req && !dc_rd_req && !dc_wr_req && rd_ph == 0 && wb_ph == 0;
      if (idle) break;
      tick();
    end
    chk(tag, idle, 1'b1);
  endtask

  function automatic logic [31:0] pool_addr();
    return 32'h8000_0000 | ((32'($urandom) % 4) << 4) | (32'($urandom) % 16);
  endfunction

  initial begin
    int n;
    reset = 1;
    {ic_rd_req, dc_rd_req, dc_wr_req} = '0;
    {ic_rd_type, dc_rd_type, dc_wr_type} = '0;
    {ic_rd_addr, dc_rd_addr, dc_wr_addr} = '0;
    dc_wr_wstrb = '0; dc_wr_data = '0;
    {mem_rd_rdy, mem_ret_valid, mem_ret_last, mem_wr_rdy, mem_wr_done} = '0;
    mem_ret_data = '0;
    @(posedge clk); #1;
    repeat (3) tick();
    reset = 0;
    tick();
    chk("wr_rdy_after_reset", obs_wr_rdy, 1'b1);

    // Single icache refill
    ic_beats = 0; dc_beats = 0;
    ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1c00_0040;
    tick();
    chk("t1_mem_rd_req_c1", mem_rd_req, 1'b1);
    chk("t1_mem_rd_addr_c1", mem_rd_addr, 32'h1c00_0040);
    drain("t1_drain");
    chk("t1_ic_beats", ic_beats, 4);
    chk("t1_dc_beats", dc_beats, 0);

    // Simultaneous reads, four rounds
    grants.delete();
    for (int r = 0; r < 4; r++) begin
      if (!ic_rd_req) begin ic_rd_req = 1; ic_rd_type = 3'($urandom); ic_rd_addr = $urandom; end
      if (!dc_rd_req) begin dc_rd_req = 1; dc_rd_type = 3'($urandom); dc_rd_addr = $urandom; end
      n = grants.size();
      for (int i = 0; i < 50 && grants.size() == n; i++) tick();
      for (int i = 0; i < 100 && rd_ph != 0; i++) tick();
    end
    ic_rd_req = 0; dc_rd_req = 0;
    drain("t2_drain");
    chk("t2_grant_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
`ifdef ARB_RR_EN
      chk($sformatf("t2_grant%0d", i), grants[i], (i % 2) == 0);
`else
      chk($sformatf("t2_grant%0d", i), grants[i], 1'b1);
`endif
    end

    // Write-back hazard with a slow write response
    fast = 1; next_done = 10;
    dc_wr_req = 1; dc_wr_type = 3'b100; dc_wr_addr = 32'h0000_1230;
    dc_wr_wstrb = 4'hf; dc_wr_data = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 20 && wb_ph != 2; i++) tick();
    ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h0000_2000;
    dc_rd_req = 1; dc_rd_type = 3'b100; dc_rd_addr = 32'h0000_1234;
    tick();
    chk("t3_ic_granted", obs_ic_rdy, 1'b1);
    chk("t3_dc_blocked", obs_dc_rdy, 1'b0);
    drain("t3_drain");
    chk("t3_dc_after_done", dc_grant_cyc, done_cyc + 1);
    fast = 0; next_done = -1;

    // Same-cycle write and read to one line
    dc_wr_req = 1; dc_wr_type = 3'($urandom); dc_wr_addr = 32'h0000_5670;
    dc_wr_wstrb = 4'($urandom); dc_wr_data = {$urandom, $urandom, $urandom, $urandom};
    dc_rd_req = 1; dc_rd_type = 3'($urandom); dc_rd_addr = 32'h0000_5678;
    tick();
    chk("t4_wr_accepted", obs_wr_rdy, 1'b1);
    chk("t4_rd_blocked", obs_dc_rdy, 1'b0);
    drain("t4_drain");
    chk("t4_rd_after_done", dc_grant_cyc, done_cyc + 1);

    // Reset while data is returning
    dc_rd_req = 1; dc_rd_type = 3'($urandom); dc_rd_addr = $urandom;
    for (int i = 0; i < 60 && !(rd_ph == 2 && beat == 2); i++) tick();
    chk("t5_reached_beat2", beat, 2);
    reset = 1;
    tick();
    chk("t5_mem_rd_req", mem_rd_req, 1'b0);
    tick();
    reset = 0;
    ic_beats = 0;
    ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = $urandom;
    drain("t5_drain");
    chk("t5_fresh_ic_beats", ic_beats, 4);

    // Back-to-back write-backs
    dc_wr_req = 1; dc_wr_type = 3'($urandom); dc_wr_addr = $urandom;
    dc_wr_wstrb = 4'($urandom); dc_wr_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    dc_wr_req = 1; dc_wr_addr = $urandom; dc_wr_data = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 60 && dc_wr_req; i++) tick();
    chk("t6_second_accept", wr_acc_cyc, done_cyc + 1);
    drain("t6_drain");

    // Random traffic on a small set of lines to provoke hazards
    for (int c = 0; c < 400; c++) begin
      if (!ic_rd_req && $urandom % 3 == 0) begin
        ic_rd_req = 1; ic_rd_type = 3'($urandom); ic_rd_addr = pool_addr();
      end
      if (!dc_rd_req && $urandom % 3 == 0) begin
        dc_rd_req = 1; dc_rd_type = 3'($urandom); dc_rd_addr = pool_addr();
      end
      if (!dc_wr_req && $urandom % 6 == 0) begin
        dc_wr_req = 1; dc_wr_type = 3'($urandom); dc_wr_addr = pool_addr();
        dc_wr_wstrb = 4'($urandom); dc_wr_data = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
    end
    drain("t7_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single cache-side memory port between the instruction cache and the data cache. Arbitrates icache and dcache line-refill reads, buffers one dcache write-back, and blocks any read that targets the line held in that buffer until memory acknowledges the write. It sits between the two cache instances and the cache-to-AXI bridge, using the same rd/ret/wr handshake the caches already expose.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, return beat width
- LINE_W, 128, write-back line width (4 words)
- clk  in  1  clock
- reset  in  1  synchronous reset, active high
- ic_rd_req / ic_rd_type / ic_rd_addr  in  1/3/ADDR_W  icache read request; held until ic_rd_rdy
- ic_rd_rdy  out  1  icache request accepted this cycle
- ic_ret_valid / ic_ret_last / ic_ret_data  out  1/1/DATA_W  icache return beats
- dc_rd_req / dc_rd_type / dc_rd_addr  in  1/3/ADDR_W  dcache read request
- dc_rd_rdy  out  1  dcache read accepted
- dc_ret_valid / dc_ret_last / dc_ret_data  out  1/1/DATA_W  dcache return beats
- dc_wr_req / dc_wr_type / dc_wr_addr / dc_wr_wstrb / dc_wr_data  in  1/3/ADDR_W/4/LINE_W  dcache write
- dc_wr_rdy  out  1  write buffer free (write accepted when dc_wr_req=1)
- mem_rd_req / mem_rd_type / mem_rd_addr  out  1/3/ADDR_W  downstream read request
- mem_rd_rdy  in  1  downstream read accepted
- mem_ret_valid / mem_ret_last / mem_ret_data  in  1/1/DATA_W  downstream return beats
- mem_wr_req / mem_wr_type / mem_wr_addr / mem_wr_wstrb / mem_wr_data  out  1/3/ADDR_W/4/LINE_W  downstream write
- mem_wr_rdy  in  1  downstream write accepted
- mem_wr_done  in  1  one-cycle pulse: write response received

## Operation
- Read FSM: R_IDLE, R_REQ, R_DATA. One read outstanding at a time.
- R_IDLE: pick a winner among the asserted rd_reqs. Assert rd_rdy to the winner only if it is not blocked by a hazard. On handshake, latch type, addr and owner, then go to R_REQ.
- R_REQ: drive mem_rd_req=1 with the latched fields. On mem_rd_rdy, go to R_DATA.
- R_DATA: route mem_ret_* combinationally to the owner; the non-owner's ret_valid stays 0. On mem_ret_valid && mem_ret_last, go to R_IDLE.
- Write FSM: W_IDLE, W_REQ, W_WAIT.
  - dc_wr_rdy = (W_IDLE). On dc_wr_req, latch all write fields and go to W_REQ.
  - W_REQ drives mem_wr_req=1. On mem_wr_rdy, go to W_WAIT.
  - In W_WAIT, mem_wr_done returns the FSM to W_IDLE.
- The read and write FSMs run concurrently.
- Hazard: a read is blocked when its addr[ADDR_W-1:4] equals the buffered write's line address while the write FSM is not in W_IDLE. It is also blocked when it equals dc_wr_addr[ADDR_W-1:4] while a write is accepted that same cycle. A blocked requester is skipped; if the other requester is unblocked, it may win.
- All return fields are passed through unmodified. No width conversion.

## Timing
- Reset values: all FSMs idle; every rdy, req and ret_valid/ret_last output is 0; all data and address outputs are 0; last_grant is set to icache.
- dc_wr_rdy rises in the first cycle after reset deasserts.
- Read latency:
  - Handshake in cycle 0 → mem_rd_req in cycle 1.
  - First forwarded beat in the same cycle as mem_ret_valid (0-cycle pass-through).
  - The next request can be accepted in the cycle after ret_last.
- Write latency: accept in cycle 0 → mem_wr_req in cycle 1. The buffer is free in the cycle after mem_wr_done.
- mem_*_req is registered and held stable until the matching rdy.
- rd_rdy and dc_wr_rdy are combinational from state and inputs.
- Reset mid-transaction returns every FSM to idle next cycle and abandons the outstanding transaction. Downstream must be reset at the same time.
- mem_wr_done outside W_WAIT is ignored. mem_ret_valid outside R_DATA is ignored.

## Configuration
- ARB_RR_EN defined: round-robin. When both requesters are eligible, grant the one not in last_grant; last_grant updates on every read handshake.
- ARB_RR_EN undefined: fixed priority, dcache over icache; last_grant is unused.

## Test plan
- Single icache read 0x1c000040 type 3'b100, 4 return beats → mem_rd_addr=0x1c000040 in cycle 1. The icache sees 4 beats with ic_ret_last on the 4th; the dcache sees none.
- Both reads asserted in the same cycle, repeated 4 times → without ARB_RR_EN all 4 grants go to the dcache. With ARB_RR_EN grants alternate, starting with the dcache.
- dcache write to 0x00001230 accepted, mem_wr_done delayed 10 cycles, then a dcache read to 0x00001234:
  - dc_rd_rdy stays 0 until the cycle after mem_wr_done.
  - An icache read to 0x00002000 issued meanwhile is granted immediately.
- Same-cycle dc_wr_req and dc_rd_req to the same line → the write is accepted, the read is blocked, and the read issues after the write completes.
- Reset asserted in R_DATA after 2 beats → next cycle mem_rd_req=0, all rdy=0 and ret_valid=0. After release, a fresh read completes normally.
- Back-to-back dcache writes → the second waits with dc_wr_rdy=0 until the first's mem_wr_done, then is accepted in the following cycle.
